// File: rtl/dstack_pkg.sv
// Shared encodings for the data-stack engine: movement commands and the
// spill/fill controller states.
package dstack_pkg;

    localparam logic [1:0] MOV_HOLD = 2'b00;
    localparam logic [1:0] MOV_PUSH = 2'b01;
    localparam logic [1:0] MOV_POP  = 2'b10;
    localparam logic [1:0] MOV_POP2 = 2'b11;

    typedef enum logic [1:0] {
        DS_IDLE  = 2'd0,
        DS_SPILL = 2'd1,
        DS_FILL  = 2'd2
    } ds_state_e;

endpackage

// File: rtl/dstack_spill_ctrl.sv
// Spill/fill sequencer: watches the on-chip fill level, owns the backing-memory
// word count and runs the one-word req/ack handshake, stalling commands meanwhile.
module dstack_spill_ctrl
    import dstack_pkg::*;
#(
    parameter int  DEPTH     = 8,
    parameter int  HI_WATER  = DEPTH - 2,
    parameter int  LO_WATER  = 2,
    parameter int  MEM_DEPTH = 16,
    localparam int CNT_W     = $clog2(DEPTH + 1),
    localparam int MCNT_W    = $clog2(MEM_DEPTH + 1),
    localparam int MADDR_W   = $clog2(MEM_DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [CNT_W-1:0]   count,
    input  logic               op_valid,
    input  logic               spill_ack,
    input  logic               fill_ack,
    output logic               op_ready,
    output logic               op_accept,
    output logic               spill_req,
    output logic               spill_done,
    output logic               fill_req,
    output logic               fill_done,
    output logic [MCNT_W-1:0]  mem_count,
    output logic [MADDR_W-1:0] mem_addr
);

    localparam logic [CNT_W-1:0]  HI_C  = CNT_W'(HI_WATER);
    localparam logic [CNT_W-1:0]  LO_C  = CNT_W'(LO_WATER);
    localparam logic [MCNT_W-1:0] MEM_C = MCNT_W'(MEM_DEPTH);

    ds_state_e state;
    logic      spill_trig;
    logic      fill_trig;

    assign spill_trig = (count >= HI_C) && (mem_count < MEM_C);
    assign fill_trig  = (count <= LO_C) && (mem_count != '0);

    // A pending trigger blocks the command in the same cycle, so the array
    // never sees a command and a transfer on the same edge.
    assign op_ready   = (state == DS_IDLE) && !spill_trig && !fill_trig;
    assign op_accept  = op_valid && op_ready;

    assign spill_req  = (state == DS_SPILL);
    assign fill_req   = (state == DS_FILL);
    assign spill_done = spill_req && spill_ack;
    assign fill_done  = fill_req && fill_ack;

    assign mem_addr   = fill_req ? MADDR_W'(mem_count - 1'b1) : MADDR_W'(mem_count);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= DS_IDLE;
            mem_count <= '0;
        end else begin
            case (state)
                DS_IDLE: begin
                    if (spill_trig) begin
                        state <= DS_SPILL;
                    end else if (fill_trig) begin
                        state <= DS_FILL;
                    end
                end
                DS_SPILL: begin
                    if (spill_ack) begin
                        state     <= DS_IDLE;
                        mem_count <= mem_count + 1'b1;
                    end
                end
                DS_FILL: begin
                    if (fill_ack) begin
                        state     <= DS_IDLE;
                        mem_count <= mem_count - 1'b1;
                    end
                end
                default: state <= DS_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/dstack_engine.sv
// Data-stack storage engine: on-chip top-of-stack shift window with push/pop/
// pop2/rotate, sticky overflow/underflow, and spill/fill to a backing memory.
module dstack_engine
    import dstack_pkg::*;
#(
    parameter int  WORD_WIDTH = 32,
    parameter int  DEPTH      = 8,
    parameter int  ROT_WIDTH  = $clog2(DEPTH),
    parameter int  HI_WATER   = DEPTH - 2,
    parameter int  LO_WATER   = 2,
    parameter int  MEM_DEPTH  = 16,
    localparam int CNT_W      = $clog2(DEPTH + 1),
    localparam int MCNT_W     = $clog2(MEM_DEPTH + 1),
    localparam int MADDR_W    = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [1:0]            movement,
    input  logic [WORD_WIDTH-1:0] next_top,
    input  logic                  rotate,
    input  logic [ROT_WIDTH-1:0]  rotate_addr,
    output logic [WORD_WIDTH-1:0] top,
    output logic [WORD_WIDTH-1:0] second,
    output logic [WORD_WIDTH-1:0] third,
    output logic [WORD_WIDTH-1:0] rotate_value,
    output logic [CNT_W-1:0]      count,
    output logic [MCNT_W-1:0]     mem_count,
    output logic [MADDR_W-1:0]    mem_addr,
    output logic                  spill_req,
    output logic [WORD_WIDTH-1:0] spill_data,
    input  logic                  spill_ack,
    output logic                  fill_req,
    input  logic [WORD_WIDTH-1:0] fill_data,
    input  logic                  fill_ack,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] TWO_C   = CNT_W'(2);

    logic [WORD_WIDTH-1:0] entry     [DEPTH];
    logic [WORD_WIDTH-1:0] entry_nxt [DEPTH];
    logic [CNT_W-1:0]      count_nxt;
    logic                  overflow_nxt;
    logic                  underflow_nxt;
    logic                  op_accept;
    logic                  spill_done;
    logic                  fill_done;

    dstack_spill_ctrl #(
        .DEPTH     (DEPTH),
        .HI_WATER  (HI_WATER),
        .LO_WATER  (LO_WATER),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_spill_ctrl (
        .clk        (clk),
        .reset      (reset),
        .count      (count),
        .op_valid   (op_valid),
        .spill_ack  (spill_ack),
        .fill_ack   (fill_ack),
        .op_ready   (op_ready),
        .op_accept  (op_accept),
        .spill_req  (spill_req),
        .spill_done (spill_done),
        .fill_req   (fill_req),
        .fill_done  (fill_done),
        .mem_count  (mem_count),
        .mem_addr   (mem_addr)
    );

    assign top          = entry[0];
    assign second       = entry[1];
    assign third        = entry[2];
    assign rotate_value = entry[rotate_addr];
    // The array is frozen while a spill is pending, so the bottom word is stable.
    assign spill_data   = spill_req ? entry[ROT_WIDTH'(count - 1'b1)] : '0;

    // NOTE: every output of this block is given its hold value first, so no
    // path through the case statements leaves a signal unassigned (no latches).
    always_comb begin
        entry_nxt     = entry;
        count_nxt     = count;
        overflow_nxt  = overflow;
        underflow_nxt = underflow;

        if (op_accept) begin
            case (movement)
                MOV_PUSH: begin
                    for (int i = DEPTH - 1; i >= 1; i--) begin
                        entry_nxt[i] = entry[i-1];
                    end
                    if (count == DEPTH_C) begin
                        overflow_nxt = 1'b1;
                    end else begin
                        count_nxt = count + 1'b1;
                    end
                end
                MOV_POP: begin
                    for (int i = 1; i < DEPTH - 1; i++) begin
                        entry_nxt[i] = entry[i+1];
                    end
                    entry_nxt[DEPTH-1] = '0;
                    if (count == '0) begin
                        underflow_nxt = 1'b1;
                    end else begin
                        count_nxt = count - 1'b1;
                    end
                end
                MOV_POP2: begin
                    for (int i = 1; i < DEPTH - 2; i++) begin
                        entry_nxt[i] = entry[i+2];
                    end
                    entry_nxt[DEPTH-2] = '0;
                    entry_nxt[DEPTH-1] = '0;
                    if (count < TWO_C) begin
                        count_nxt     = '0;
                        underflow_nxt = 1'b1;
                    end else begin
                        count_nxt = count - TWO_C;
                    end
                end
                default: begin
                    // Rotate slides entries 0..n-1 down one slot; entry n is consumed
                    // through next_top by the stack control.
                    if (rotate) begin
                        for (int i = 1; i < DEPTH; i++) begin
                            if (ROT_WIDTH'(i) <= rotate_addr) begin
                                entry_nxt[i] = entry[i-1];
                            end
                        end
                    end
                end
            endcase
            entry_nxt[0] = next_top;
        end else if (spill_done) begin
            entry_nxt[ROT_WIDTH'(count - 1'b1)] = '0;
            count_nxt = count - 1'b1;
        end else if (fill_done) begin
            entry_nxt[ROT_WIDTH'(count)] = fill_data;
            count_nxt = count + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the window is reset word by word because every entry is
            // architecturally visible through rotate_value and spill_data.
            for (int i = 0; i < DEPTH; i++) begin
                entry[i] <= '0;
            end
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            entry     <= entry_nxt;
            count     <= count_nxt;
            overflow  <= overflow_nxt;
            underflow <= underflow_nxt;
        end
    end

endmodule

// File: tb/tb_dstack_engine.sv
// Self-checking bench for dstack_engine: table vectors, directed spill/fill,
// overflow/underflow and async-reset sequences, then a randomized model run.
module tb_dstack_engine;
    import dstack_pkg::*;

    localparam int W  = 32;
    localparam int D  = 8;
    localparam int HI = 6;
    localparam int LO = 2;
    localparam int MD = 16;

    logic          clk;
    logic          reset;
    logic          op_valid;
    logic          op_ready;
    logic [1:0]    movement;
    logic [W-1:0]  next_top;
    logic          rotate;
    logic [2:0]    rotate_addr;
    logic [W-1:0]  top;
    logic [W-1:0]  second;
    logic [W-1:0]  third;
    logic [W-1:0]  rotate_value;
    logic [3:0]    count;
    logic [4:0]    mem_count;
    logic [3:0]    mem_addr;
    logic          spill_req;
    logic [W-1:0]  spill_data;
    logic          spill_ack;
    logic          fill_req;
    logic [W-1:0]  fill_data;
    logic          fill_ack;
    logic          overflow;
    logic          underflow;

    int n_vec  = 0;
    int n_miss = 0;

    logic [W-1:0] dmem [$];

    dstack_engine #(
        .WORD_WIDTH (W),
        .DEPTH      (D),
        .ROT_WIDTH  (3),
        .HI_WATER   (HI),
        .LO_WATER   (LO),
        .MEM_DEPTH  (MD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .movement     (movement),
        .next_top     (next_top),
        .rotate       (rotate),
        .rotate_addr  (rotate_addr),
        .top          (top),
        .second       (second),
        .third        (third),
        .rotate_value (rotate_value),
        .count        (count),
        .mem_count    (mem_count),
        .mem_addr     (mem_addr),
        .spill_req    (spill_req),
        .spill_data   (spill_data),
        .spill_ack    (spill_ack),
        .fill_req     (fill_req),
        .fill_data    (fill_data),
        .fill_ack     (fill_ack),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        op_valid    = 1'b0;
        movement    = MOV_HOLD;
        next_top    = '0;
        rotate      = 1'b0;
        rotate_addr = '0;
        spill_ack   = 1'b0;
        fill_ack    = 1'b0;
        fill_data   = '0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_top"},        64'(top), 0);
        check({tag, "_second"},     64'(second), 0);
        check({tag, "_count"},      64'(count), 0);
        check({tag, "_mem_count"},  64'(mem_count), 0);
        check({tag, "_op_ready"},   64'(op_ready), 1);
        check({tag, "_spill_req"},  64'(spill_req), 0);
        check({tag, "_fill_req"},   64'(fill_req), 0);
        check({tag, "_spill_data"}, 64'(spill_data), 0);
        check({tag, "_overflow"},   64'(overflow), 0);
        check({tag, "_underflow"},  64'(underflow), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        dmem.delete();
        @(negedge clk);
        #1 check_reset_values("rst");
        reset = 1'b0;
    endtask

    // Issue one command, servicing any spill/fill immediately until it is accepted.
    task automatic do_op(input logic [1:0] mov, input logic [W-1:0] nt,
                         input logic rot, input logic [2:0] raddr);
        int budget = 40;
        bit done   = 1'b0;
        movement    = mov;
        next_top    = nt;
        rotate      = rot;
        rotate_addr = raddr;
        op_valid    = 1'b1;
        while (!done && budget > 0) begin
            #1;
            if (op_ready) begin
                @(posedge clk);
                done = 1'b1;
            end else begin
                spill_ack = spill_req;
                fill_ack  = fill_req;
                if (spill_req) dmem.push_back(spill_data);
                if (fill_req && dmem.size() > 0) fill_data = dmem.pop_back();
                @(posedge clk);
            end
            @(negedge clk);
            spill_ack = 1'b0;
            fill_ack  = 1'b0;
            budget--;
        end
        op_valid = 1'b0;
        rotate   = 1'b0;
        if (!done) check("op_accept_timeout", 0, 1);
    endtask

    typedef struct {
        logic [1:0]   mov;
        logic [W-1:0] nt;
        logic         rot;
        logic [2:0]   raddr;
        logic [W-1:0] e_rv;
        logic [W-1:0] e_top;
        logic [W-1:0] e_sec;
        logic [W-1:0] e_thd;
        logic [3:0]   e_cnt;
    } vec_t;

    vec_t tbl [10];

    // Reference model state: window as a queue (index 0 = top), memory as a queue.
    logic [W-1:0] q  [$];
    logic [W-1:0] mq [$];
    int           m_cnt;
    int           m_mode;
    bit           m_ovf;
    bit           m_unf;

    task automatic model_init();
        q.delete();
        mq.delete();
        for (int i = 0; i < D; i++) q.push_back('0);
        m_cnt  = 0;
        m_mode = 0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endtask

    task automatic model_apply(input logic [1:0] mov, input logic [W-1:0] nt,
                               input logic rot, input logic [2:0] raddr);
        case (mov)
            MOV_PUSH: begin
                q.push_front(nt);
                void'(q.pop_back());
                if (m_cnt == D) m_ovf = 1'b1;
                else m_cnt++;
            end
            MOV_POP: begin
                q.delete(0);
                q[0] = nt;
                q.push_back('0);
                if (m_cnt < 1) begin m_cnt = 0; m_unf = 1'b1; end
                else m_cnt--;
            end
            MOV_POP2: begin
                q.delete(0);
                q.delete(0);
                q[0] = nt;
                q.push_back('0);
                q.push_back('0);
                if (m_cnt < 2) begin m_cnt = 0; m_unf = 1'b1; end
                else m_cnt -= 2;
            end
            default: begin
                if (rot) begin
                    q.delete(int'(raddr));
                    q.push_front(nt);
                end else begin
                    q[0] = nt;
                end
            end
        endcase
    endtask

    task automatic random_run(input int cycles);
        bit ts, tf, rdy;
        int r, phase;
        logic [W-1:0] exp_sd;
        model_init();
        for (int cyc = 0; cyc < cycles; cyc++) begin
            @(negedge clk);
            phase    = (cyc / 120) % 2;
            op_valid = ($urandom_range(0, 3) != 0);
            r        = $urandom_range(0, 99);
            if (phase == 0) movement = (r < 55) ? MOV_PUSH : (r < 75) ? MOV_POP : (r < 80) ? MOV_POP2 : MOV_HOLD;
            else            movement = (r < 20) ? MOV_PUSH : (r < 60) ? MOV_POP : (r < 75) ? MOV_POP2 : MOV_HOLD;
            rotate      = (movement == MOV_HOLD) && ($urandom_range(0, 1) == 1);
            rotate_addr = 3'($urandom_range(0, 7));
            next_top    = $urandom;
            if (movement == MOV_PUSH && $urandom_range(0, 3) == 0) next_top = q[rotate_addr];
            spill_ack = ($urandom_range(0, 2) == 0);
            fill_ack  = ($urandom_range(0, 2) == 0);
            fill_data = (m_mode == 2 && mq.size() > 0) ? mq[$] : $urandom;
            #1;
            ts  = (m_cnt >= HI) && (mq.size() < MD);
            tf  = (m_cnt <= LO) && (mq.size() > 0);
            rdy = (m_mode == 0) && !ts && !tf;
            exp_sd = (m_mode == 1) ? q[m_cnt-1] : '0;
            check("rnd_top",        64'(top), 64'(q[0]));
            check("rnd_second",     64'(second), 64'(q[1]));
            check("rnd_third",      64'(third), 64'(q[2]));
            check("rnd_rotate_val", 64'(rotate_value), 64'(q[rotate_addr]));
            check("rnd_count",      64'(count), 64'(m_cnt));
            check("rnd_mem_count",  64'(mem_count), 64'(mq.size()));
            check("rnd_op_ready",   64'(op_ready), 64'(rdy));
            check("rnd_spill_req",  64'(spill_req), 64'(m_mode == 1));
            check("rnd_fill_req",   64'(fill_req), 64'(m_mode == 2));
            check("rnd_spill_data", 64'(spill_data), 64'(exp_sd));
            check("rnd_overflow",   64'(overflow), 64'(m_ovf));
            check("rnd_underflow",  64'(underflow), 64'(m_unf));
            if (m_mode == 1) check("rnd_spill_addr", 64'(mem_addr), 64'(mq.size() % MD));
            if (m_mode == 2) check("rnd_fill_addr",  64'(mem_addr), 64'(mq.size() - 1));
            case (m_mode)
                0: begin
                    if (op_valid && rdy) model_apply(movement, next_top, rotate, rotate_addr);
                    m_mode = ts ? 1 : (tf ? 2 : 0);
                end
                1: begin
                    if (spill_ack) begin
                        mq.push_back(q[m_cnt-1]);
                        q[m_cnt-1] = '0;
                        m_cnt--;
                        m_mode = 0;
                    end
                end
                default: begin
                    if (fill_ack) begin
                        q[m_cnt] = fill_data;
                        void'(mq.pop_back());
                        m_cnt++;
                        m_mode = 0;
                    end
                end
            endcase
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();

        tbl[0] = '{MOV_PUSH, 32'd1, 1'b0, 3'd0, 32'd0, 32'd1, 32'd0, 32'd0, 4'd1};
        tbl[1] = '{MOV_PUSH, 32'd2, 1'b0, 3'd0, 32'd1, 32'd2, 32'd1, 32'd0, 4'd2};
        tbl[2] = '{MOV_PUSH, 32'd3, 1'b0, 3'd0, 32'd2, 32'd3, 32'd2, 32'd1, 4'd3};
        tbl[3] = '{MOV_POP,  32'd5, 1'b0, 3'd0, 32'd3, 32'd5, 32'd1, 32'd0, 4'd2};
        tbl[4] = '{MOV_PUSH, 32'd7, 1'b0, 3'd0, 32'd5, 32'd7, 32'd5, 32'd1, 4'd3};
        tbl[5] = '{MOV_PUSH, 32'd1, 1'b0, 3'd2, 32'd1, 32'd1, 32'd7, 32'd5, 4'd4};
        tbl[6] = '{MOV_HOLD, 32'd5, 1'b1, 3'd2, 32'd5, 32'd5, 32'd1, 32'd7, 4'd4};
        tbl[7] = '{MOV_HOLD, 32'd9, 1'b0, 3'd0, 32'd5, 32'd9, 32'd1, 32'd7, 4'd4};
        tbl[8] = '{MOV_POP2, 32'd3, 1'b0, 3'd3, 32'd1, 32'd3, 32'd1, 32'd0, 4'd2};
        tbl[9] = '{MOV_HOLD, 32'd4, 1'b1, 3'd0, 32'd3, 32'd4, 32'd1, 32'd0, 4'd2};

        // Table-driven push/pop/copy/rotate vectors from reset.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            movement    = tbl[k].mov;
            next_top    = tbl[k].nt;
            rotate      = tbl[k].rot;
            rotate_addr = tbl[k].raddr;
            op_valid    = 1'b1;
            #1;
            check("tbl_rotate_value", 64'(rotate_value), 64'(tbl[k].e_rv));
            check("tbl_op_ready",     64'(op_ready), 1);
            @(posedge clk);
            @(negedge clk);
            op_valid = 1'b0;
            rotate   = 1'b0;
            #1;
            check("tbl_top",    64'(top),    64'(tbl[k].e_top));
            check("tbl_second", 64'(second), 64'(tbl[k].e_sec));
            check("tbl_third",  64'(third),  64'(tbl[k].e_thd));
            check("tbl_count",  64'(count),  64'(tbl[k].e_cnt));
        end

        // Rotate over a window built from pushes 10..17 (with spills in between).
        do_reset();
        for (int v = 10; v <= 17; v++) do_op(MOV_PUSH, W'(v), 1'b0, 3'd0);
        rotate_addr = 3'd3;
        #1 check("rot_value_pre", 64'(rotate_value), 64'd14);
        do_op(MOV_HOLD, 32'd14, 1'b1, 3'd3);
        #1;
        check("rot_top",       64'(top), 64'd14);
        check("rot_second",    64'(second), 64'd17);
        check("rot_third",     64'(third), 64'd16);
        check("rot_count",     64'(count), 64'd5);
        check("rot_mem_count", 64'(mem_count), 64'd3);
        rotate_addr = 3'd3;
        #1 check("rot_entry3", 64'(rotate_value), 64'd15);
        rotate_addr = 3'd4;
        #1 check("rot_entry4", 64'(rotate_value), 64'd13);

        // Spill handshake with a delayed ack and a command held through it.
        do_reset();
        for (int v = 1; v <= 6; v++) do_op(MOV_PUSH, W'(v), 1'b0, 3'd0);
        #1;
        check("spill_trig_count", 64'(count), 64'd6);
        check("spill_trig_ready", 64'(op_ready), 0);
        check("spill_trig_req",   64'(spill_req), 0);
        movement = MOV_HOLD;
        next_top = 32'h66;
        op_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            check("spill_req_high", 64'(spill_req), 1);
            check("spill_data",     64'(spill_data), 64'd1);
            check("spill_addr",     64'(mem_addr), 64'd0);
            check("spill_ready",    64'(op_ready), 0);
            check("spill_top_held", 64'(top), 64'd6);
        end
        spill_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        spill_ack = 1'b0;
        #1;
        check("spill_done_req",   64'(spill_req), 0);
        check("spill_done_count", 64'(count), 64'd5);
        check("spill_done_mem",   64'(mem_count), 64'd1);
        check("spill_done_ready", 64'(op_ready), 1);
        check("spill_done_top",   64'(top), 64'd6);
        @(negedge clk);
        op_valid = 1'b0;
        #1;
        check("after_spill_accept_top", 64'(top), 64'h66);
        check("after_spill_count",      64'(count), 64'd5);

        // Pop down to the low-water mark, then fill 0xAB.
        do_op(MOV_POP, 32'h70, 1'b0, 3'd0);
        do_op(MOV_POP, 32'h71, 1'b0, 3'd0);
        do_op(MOV_POP, 32'h72, 1'b0, 3'd0);
        #1;
        check("fill_trig_count", 64'(count), 64'd2);
        check("fill_trig_ready", 64'(op_ready), 0);
        check("fill_trig_req",   64'(fill_req), 0);
        @(negedge clk);
        #1;
        check("fill_req_high", 64'(fill_req), 1);
        check("fill_addr",     64'(mem_addr), 64'd0);
        fill_ack  = 1'b1;
        fill_data = 32'hAB;
        @(posedge clk);
        @(negedge clk);
        fill_ack  = 1'b0;
        fill_data = '0;
        #1;
        check("fill_third",     64'(third), 64'hAB);
        check("fill_top",       64'(top), 64'h72);
        check("fill_second",    64'(second), 64'd2);
        check("fill_count",     64'(count), 64'd3);
        check("fill_mem_count", 64'(mem_count), 64'd0);
        check("fill_req_low",   64'(fill_req), 0);
        spill_ack = 1'b1;
        fill_ack  = 1'b1;
        @(negedge clk);
        spill_ack = 1'b0;
        fill_ack  = 1'b0;
        #1;
        check("stray_ack_count", 64'(count), 64'd3);
        check("stray_ack_mem",   64'(mem_count), 64'd0);
        check("stray_ack_third", 64'(third), 64'hAB);

        // Underflow, then async reset while a spill request is outstanding.
        do_reset();
        do_op(MOV_PUSH, 32'h11, 1'b0, 3'd0);
        do_op(MOV_POP2, 32'h22, 1'b0, 3'd0);
        #1;
        check("unf_count", 64'(count), 64'd0);
        check("unf_flag",  64'(underflow), 1);
        check("unf_top",   64'(top), 64'h22);
        check("unf_ovf",   64'(overflow), 0);
        do_op(MOV_POP, 32'h33, 1'b0, 3'd0);
        #1 check("unf_pop_empty_count", 64'(count), 64'd0);
        for (int v = 1; v <= 6; v++) do_op(MOV_PUSH, W'(v), 1'b0, 3'd0);
        @(negedge clk);
        #1;
        check("unf_sticky",     64'(underflow), 1);
        check("pre_reset_req",  64'(spill_req), 1);
        #2 reset = 1'b1;
        #1 check_reset_values("async_rst");
        @(negedge clk);
        reset = 1'b0;

        // Overflow once the backing memory is full.
        do_reset();
        for (int v = 1; v <= 24; v++) do_op(MOV_PUSH, W'(v), 1'b0, 3'd0);
        #1;
        check("ovf_pre_count", 64'(count), 64'd8);
        check("ovf_pre_mem",   64'(mem_count), 64'd16);
        check("ovf_pre_flag",  64'(overflow), 0);
        check("ovf_pre_ready", 64'(op_ready), 1);
        do_op(MOV_PUSH, 32'd25, 1'b0, 3'd0);
        rotate_addr = 3'd7;
        #1;
        check("ovf_flag",     64'(overflow), 1);
        check("ovf_count",    64'(count), 64'd8);
        check("ovf_top",      64'(top), 64'd25);
        check("ovf_bottom",   64'(rotate_value), 64'd18);
        @(negedge clk);
        #1;
        check("ovf_no_spill", 64'(spill_req), 0);
        check("ovf_sticky",   64'(overflow), 1);

        // Randomized runs against the queue-based model.
        do_reset();
        random_run(1200);
        do_reset();
        random_run(1200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
